ehl_clock_div_monitor: RTL

Receive-side checker for a divided clock. Samples the output of a clock divider in the source clock domain, measures the high and low phase lengths in source-clock cycles, and flags any deviation from the expected division ratio and duty cycle. Used in silicon self-test and in mapped-vs-RTL equivalence benches next to the clock divider it watches.

---
 rtl/ehl_clock_div_monitor_pkg.sv | 37 +++
 rtl/ehl_clock_div_monitor_if.sv | 36 +++
 rtl/ehl_clock_div_monitor_edge.sv | 55 +++++
 rtl/ehl_clock_div_monitor.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/ehl_clock_div_monitor_pkg.sv
// ---------------------------------------------------------------------------
// ehl_clock_mon_pkg
// Shared types and helpers for the divided-clock monitor.
//   mon_state_e : HUNT (waiting for the first edge) / MEAS (checking phases)
//   high_exp()  : expected high-phase length for a division ratio
//   low_exp()   : expected low-phase length for a division ratio
//   stuck_th()  : phase length at which a missing edge is declared stuck
// ---------------------------------------------------------------------------
package ehl_clock_mon_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        MEAS = 1'b1
    } mon_state_e;

    // Good-period counter width; LOCK_PERIODS is limited to 1..15.
    localparam int GOOD_W = 4;

    // Odd ratios put the extra cycle in the high phase.
    function automatic int high_exp(input int div);
        return (div + 1) / 2;
    endfunction

    function automatic int low_exp(input int div);
        return div / 2;
    endfunction

    // One cycle longer than the longest legal phase.
    function automatic int stuck_th(input int div);
        int hi;
        int lo;
        hi = high_exp(div);
        lo = low_exp(div);
        return ((hi > lo) ? hi : lo) + 1;
    endfunction

endpackage

// File: rtl/ehl_clock_div_monitor_if.sv
// ---------------------------------------------------------------------------
// ehl_clock_div_monitor_if
// Bundles the divided clock under test with the monitor status outputs.
//   clk_div : divided clock under test
//   locked  : divided clock verified stable
//   err     : one-cycle pulse per violation
//   err_cnt : saturating violation count
//   period  : last measured full period in source-clock cycles
// Modports: master = divider/observer side, slave = monitor side.
// ---------------------------------------------------------------------------
interface ehl_clock_div_monitor_if #(
    parameter int CNT_W = 8,
    parameter int ERR_W = 8
);
    logic             clk_div;
    logic             locked;
    logic             err;
    logic [ERR_W-1:0] err_cnt;
    logic [CNT_W-1:0] period;

    modport master (
        output clk_div,
        input  locked,
        input  err,
        input  err_cnt,
        input  period
    );

    modport slave (
        input  clk_div,
        output locked,
        output err,
        output err_cnt,
        output period
    );
endinterface

// File: rtl/ehl_clock_div_monitor_edge.sv
// ---------------------------------------------------------------------------
// ehl_edge_detect
// Samples the divided clock in the source domain and reports its edges.
//   clk_i   : source clock
//   rst_ni  : synchronous active-low reset
//   d_i     : divided clock input
//   rise_o  : rising edge seen on the sampled signal (combinational pulse)
//   fall_o  : falling edge seen on the sampled signal (combinational pulse)
// Macro EHL_CLOCK_MON_SYNC_EN inserts a 2-flop synchronizer ahead of the
// sample register for asynchronous or glitchy inputs (+2 cycles latency).
// ---------------------------------------------------------------------------
module ehl_edge_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);
    logic samp_in;
    logic s_q;
    logic s_prev_q;

`ifdef EHL_CLOCK_MON_SYNC_EN
    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
        end
    end

    assign samp_in = sync2_q;
`else
    assign samp_in = d_i;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s_q      <= 1'b0;
            s_prev_q <= 1'b0;
        end else begin
            s_q      <= samp_in;
            s_prev_q <= s_q;
        end
    end

    assign rise_o =  s_q & ~s_prev_q;
    assign fall_o = ~s_q &  s_prev_q;

endmodule

// File: rtl/ehl_clock_div_monitor.sv
// ---------------------------------------------------------------------------
// ehl_clock_div_monitor
// Receive-side checker for a divided clock: measures high/low phase lengths
// in clk_in cycles and flags deviations from the expected ratio and duty.
//   clk_in  : source clock
//   reset_n : synchronous active-low reset
//   mon     : ehl_clock_div_monitor_if.slave (clk_div in; locked, err,
//             err_cnt, period out)
// Parameters: DIV, LOCK_PERIODS, CNT_W, ERR_W.
// Optional macro EHL_CLOCK_MON_SYNC_EN: synchronizer on clk_div (see
// ehl_edge_detect).
// ---------------------------------------------------------------------------
module ehl_clock_div_monitor
    import ehl_clock_mon_pkg::*;
#(
    parameter int DIV          = 2,
    parameter int LOCK_PERIODS = 4,
    parameter int CNT_W        = 8,
    parameter int ERR_W        = 8
) (
    input  logic                    clk_in,
    input  logic                    reset_n,
    ehl_clock_div_monitor_if.slave  mon
);
    localparam logic [CNT_W-1:0]  HIGH_EXP = CNT_W'(high_exp(DIV));
    localparam logic [CNT_W-1:0]  LOW_EXP  = CNT_W'(low_exp(DIV));
    localparam logic [CNT_W-1:0]  STUCK_TH = CNT_W'(stuck_th(DIV));
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [ERR_W-1:0]  ERR_MAX  = '1;
    localparam logic [GOOD_W-1:0] LOCK_N   = GOOD_W'(LOCK_PERIODS);

    logic rise;
    logic fall;
    logic edge_seen;

    mon_state_e        state_q,    state_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic [CNT_W-1:0]  high_len_q, high_len_d;
    logic              high_ok_q,  high_ok_d;
    logic [GOOD_W-1:0] good_q,     good_d;
    logic              locked_q,   locked_d;
    logic              err_q,      err_d;
    logic [ERR_W-1:0]  err_cnt_q,  err_cnt_d;
    logic [CNT_W-1:0]  period_q,   period_d;
    logic              viol;

    ehl_edge_detect u_edge (
        .clk_i  (clk_in),
        .rst_ni (reset_n),
        .d_i    (mon.clk_div),
        .rise_o (rise),
        .fall_o (fall)
    );

    assign edge_seen = rise | fall;

    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            state_q    <= HUNT;
            cnt_q      <= '0;
            high_len_q <= '0;
            high_ok_q  <= 1'b0;
            good_q     <= '0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
            period_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            high_len_q <= high_len_d;
            high_ok_q  <= high_ok_d;
            good_q     <= good_d;
            locked_q   <= locked_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
            period_q   <= period_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        high_len_d = high_len_q;
        high_ok_d  = high_ok_q;
        good_d     = good_q;
        period_d   = period_q;
        viol       = 1'b0;

        // cnt_q holds the length of the phase that an edge just closed.
        if (edge_seen) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            HUNT: begin
                // The phase before the first edge has unknown length, so the
                // first high phase only counts once it is fully observed.
                high_len_d = '0;
                high_ok_d  = 1'b0;
                if (edge_seen) begin
                    state_d = MEAS;
                end
            end
            MEAS: begin
                if (fall) begin
                    high_len_d = cnt_q;
                    high_ok_d  = (cnt_q == HIGH_EXP);
                    viol       = (cnt_q != HIGH_EXP);
                end else if (rise) begin
                    period_d = high_len_q + cnt_q;
                    if (cnt_q != LOW_EXP) begin
                        viol = 1'b1;
                    end else if (high_ok_q && (good_q != LOCK_N)) begin
                        good_d = good_q + 1'b1;
                    end
                end else if (cnt_q >= STUCK_TH) begin
                    // Edge has priority; stuck only fires on a quiet cycle.
                    viol    = 1'b1;
                    state_d = HUNT;
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase

        if (viol) begin
            good_d = '0;
        end

        locked_d  = (good_d == LOCK_N);
        err_d     = viol;
        err_cnt_d = (viol && (err_cnt_q != ERR_MAX)) ? err_cnt_q + 1'b1 : err_cnt_q;
    end

    assign mon.locked  = locked_q;
    assign mon.err     = err_q;
    assign mon.err_cnt = err_cnt_q;
    assign mon.period  = period_q;

endmodule
